conv_row_sequencer: RTL and testbench
=====================================

# conv_row_sequencer

Sequential controller directly upstream of the receptive-field selector in the convolution layer. It steps `rowNumber`/`column` over every half-row of the output feature map and pulses the convolution units for each one. It then captures each half-row of results into a flat output-image register and signals completion. It turns the combinational selector-plus-conv-unit datapath into a complete, restartable layer pass.

## Interface
- `DATA_WIDTH`, 16: bits per pixel/result.
- `D`, 1: input depth; passed through, no effect on sequencing.
- `H`, 32: input image height.
- `W`, 32: input image width.
- `F`, 5: filter size.
- Derived: `OH = H-F+1`, `OW = W-F+1`, `HALF = OW/2`. `OW` must be even; elaboration fails otherwise.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk`.
- `start` in 1: begin a layer pass. Honoured only in IDLE.
- `conv_done` in 1: conv units have valid `conv_result` this cycle.
- `conv_result` in `HALF*DATA_WIDTH`: half-row of results. Element j is at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `rowNumber` out 11: output row currently selected; drives the selector.
- `column` out 11: half-row select to the selector. 0 = first half, 1 = second half.
- `conv_start` out 1: one-cycle pulse telling the conv units to sample the selector output.
- `output_image` out `OH*OW*DATA_WIDTH`: result (r,c) is at `[(r*OW+c)*DATA_WIDTH +: DATA_WIDTH]`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE. Moore outputs:
  - `conv_start = (state==ISSUE)`
  - `done = (state==DONE)`
  - `busy = (state!=IDLE)`
- IDLE: on `start=1`, load `rowNumber=0` and `column=0`, go to ISSUE. `output_image` is not cleared; each slice is overwritten when its half-row completes.
- ISSUE: one cycle, then WAIT. `conv_done` is ignored in this state.
- WAIT: hold until `conv_done=1`. On that edge, write `conv_result` element j to `output_image` element (`rowNumber`, `column*HALF + j`) for j = 0..HALF-1, then go to ADVANCE. Nothing else in `output_image` changes.
- ADVANCE:
  - If `column==0`: set `column=1`, go to ISSUE.
  - Else if `rowNumber==OH-1`: go to DONE.
  - Else: `rowNumber++`, `column=0`, go to ISSUE.
- DONE: one cycle, then IDLE. `rowNumber`/`column` hold their last values (OH-1, 1) until the next `start`.
- `start` while busy is ignored and is not queued. Holding `start` high in DONE's exit cycle (i.e. while in IDLE) starts a new pass.
- `rowNumber`/`column` are zero-extended to 11 bits. Upper bits are always 0 for `OH ≤ 2047`.

## Timing
- Reset (`reset=0` at an edge), from any state including mid-pass:
  - state = IDLE
  - `rowNumber` = 0, `column` = 0
  - `output_image` = 0
  - `conv_start`, `busy`, `done` = 0
- `rowNumber`/`column` are registered and change only on the IDLE→ISSUE and ADVANCE→ISSUE edges. They are therefore stable for the whole ISSUE+WAIT window, so the combinational selector has settled before `conv_start`.
- Per half-row: 2 + N cycles, where N ≥ 1 is the number of WAIT cycles until `conv_done`.
- With `conv_done` tied high, `start` sampled at edge 0 gives:
  - `conv_start` first high in cycle 1.
  - `done` high in cycle `1 + 3*2*OH` (cycle 169 for the defaults).
- `conv_result` is sampled only on the WAIT edge where `conv_done=1`. Extra `conv_done` pulses in other states have no effect.

## Structure
- Shared package `conv_pkg`:
  - localparam functions or macros for `OH`, `OW`, `HALF`.
  - state encoding (3-bit, IDLE=0).
  - the `output_image` index formula, so the selector and downstream pooling agree on the layout.
- Single module, no sub-module. The write is an indexed part-select loop over HALF elements. If the writeback is reused by the pooling stage, it may be split out as `half_row_writer`.

## Test plan
- Reset mid-pass: `start`, run to `rowNumber=3`, drive `reset=0` for one edge → IDLE, all outputs 0, `output_image` all zero.
- Full pass, `conv_done` tied high, `conv_result` element j = `{rowNumber[7:0], column[0], j[6:0]}` → `done` at cycle 169. Every `output_image` element (r,c) matches `{r, c/14, c%14}`. Exactly 56 `conv_start` pulses.
- Variable latency: `conv_done` after 1, 4, 0-gap, and 7 WAIT cycles → `rowNumber`/`column` stable throughout WAIT. Writes occur only on `conv_done` edges.
- Spurious `conv_done` during ISSUE and ADVANCE, with garbage `conv_result` → no `output_image` change.
- `start` pulsed while busy → no restart, cycle count unchanged. `start` held through DONE → second pass begins in the IDLE cycle after DONE.
- Parameter sweep H=W=8, F=3 (OH=OW=6, HALF=3) → 12 half-rows, `done` at cycle 37, layout correct.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer: layer geometry helpers,
// the row-sequencer state encoding and the flat output-image layout.
package conv_pkg;

  // Width of the rowNumber/column buses presented to the selector
  localparam int ROW_IDX_W = 11;

  // Row sequencer states; IDLE must encode as zero
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  // Output feature-map height for an HxW image and an FxF filter
  function automatic int calc_oh(input int h, input int f);
    return h - f + 1;
  endfunction

  // Output feature-map width
  function automatic int calc_ow(input int w, input int f);
    return w - f + 1;
  endfunction

  // Number of results produced by the conv units per half-row
  function automatic int calc_half(input int w, input int f);
    return (w - f + 1) / 2;
  endfunction

  // Element index of result (r,c) in the flat output image; multiply by the
  // pixel width to get the bit offset. Selector and pooling use the same layout.
  function automatic int img_index(input int r, input int c, input int ow);
    return r * ow + c;
  endfunction

endpackage

// File: rtl/conv_row_sequencer.sv
// Convolution-layer row sequencer. Walks rowNumber/column over every half-row
// of the output feature map, pulses the conv units for each one, captures the
// returned half-row into the flat output image and pulses done at the end.
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic                                                   conv_done,
  input  logic [calc_half(W, F)*DATA_WIDTH-1:0]                  conv_result,
  output logic [ROW_IDX_W-1:0]                                   rowNumber,
  output logic [ROW_IDX_W-1:0]                                   column,
  output logic                                                   conv_start,
  output logic [calc_oh(H, F)*calc_ow(W, F)*DATA_WIDTH-1:0]      output_image,
  output logic                                                   busy,
  output logic                                                   done
);

  localparam int OH    = calc_oh(H, F);
  localparam int OW    = calc_ow(W, F);
  localparam int HALF  = calc_half(W, F);
  localparam int IMG_W = OH * OW * DATA_WIDTH;

  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(OH - 1);

  // Reject geometries the half-row split or the row bus cannot represent
  generate
    if ((OW % 2) != 0) begin : g_ow_odd
      $error("conv_row_sequencer: output width OW=%0d must be even", OW);
    end
    if (OH < 1 || OH > 2047) begin : g_oh_range
      $error("conv_row_sequencer: output height OH=%0d out of range", OH);
    end
    if (D < 1) begin : g_depth
      $error("conv_row_sequencer: depth D=%0d must be at least 1", D);
    end
  endgenerate

  seq_state_e           state_q, state_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic                 col_q, col_d;
  logic [IMG_W-1:0]     image_q, image_d;
  logic                 conv_start_q, conv_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, row/column stepping, half-row writeback and Moore outputs
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    image_d = image_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_done) begin
          for (int j = 0; j < HALF; j++) begin
            image_d[img_index(int'(row_q), int'(col_q) * HALF + j, OW) * DATA_WIDTH +: DATA_WIDTH] =
              conv_result[j * DATA_WIDTH +: DATA_WIDTH];
          end
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (!col_q) begin
          col_d   = 1'b1;
          state_d = ST_ISSUE;
        end else if (row_q == ROW_LAST) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          col_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    conv_start_d = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  // State and registered outputs; reset clears everything including the image
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= 1'b0;
      image_q      <= '0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      image_q      <= image_d;
      conv_start_q <= conv_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rowNumber    = row_q;
  assign column       = {{(ROW_IDX_W-1){1'b0}}, col_q};
  assign conv_start   = conv_start_q;
  assign output_image = image_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Bench for conv_row_sequencer: default 32x32/F=5 instance driven by a
// conv-unit model with programmable latency, plus an 8x8/F=3 instance.
`timescale 1ns/1ps
module tb_conv_row_sequencer;

  localparam int DW     = 16;
  localparam int OH_A   = 28;
  localparam int OW_A   = 28;
  localparam int HALF_A = 14;
  localparam int OH_B   = 6;
  localparam int OW_B   = 6;
  localparam int HALF_B = 3;
  localparam int IMG_A  = OH_A * OW_A * DW;
  localparam int IMG_B  = OH_B * OW_B * DW;

  typedef struct {
    logic [10:0] row;
    logic [10:0] col;
  } req_t;

  typedef struct {
    int done_edge;
    int pulses;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                 start_a = 1'b0;
  logic                 conv_done_a = 1'b0;
  logic [HALF_A*DW-1:0] conv_result_a = '0;
  logic [10:0]          row_a, col_a;
  logic                 conv_start_a, busy_a, done_a;
  logic [IMG_A-1:0]     image_a;

  logic                 start_b = 1'b0;
  logic                 conv_done_b;
  logic [HALF_B*DW-1:0] conv_result_b;
  logic [10:0]          row_b, col_b;
  logic                 conv_start_b, busy_b, done_b;
  logic [IMG_B-1:0]     image_b;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  req_t      req_q[$];
  done_exp_t done_q[$];
  logic [IMG_A-1:0] exp_flat_a = '0;

  bit          m_lat_var = 1'b0;
  bit          m_spur = 1'b0;
  logic [DW-1:0] m_xor = '0;
  int          m_k = 0;
  int          m_state = 0;
  int          m_cnt = 0;
  int          m_lat = 1;
  int          m_row = 0;
  int          m_col = 0;
  int          lat_tab[4] = '{1, 4, 1, 7};

  conv_row_sequencer #(.DATA_WIDTH(DW), .D(1), .H(32), .W(32), .F(5)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .conv_done(conv_done_a),
    .conv_result(conv_result_a), .rowNumber(row_a), .column(col_a),
    .conv_start(conv_start_a), .output_image(image_a), .busy(busy_a), .done(done_a)
  );

  conv_row_sequencer #(.DATA_WIDTH(DW), .D(1), .H(8), .W(8), .F(3)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .conv_done(conv_done_b),
    .conv_result(conv_result_b), .rowNumber(row_b), .column(col_b),
    .conv_start(conv_start_b), .output_image(image_b), .busy(busy_b), .done(done_b)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Absolute edge counter used to time done pulses
  always @(posedge clk) edges <= edges + 1;

  // The small instance's conv units answer every cycle with a tagged half-row
  assign conv_done_b = 1'b1;
  always_comb begin
    conv_result_b = '0;
    for (int j = 0; j < HALF_B; j++)
      conv_result_b[j*DW +: DW] = {row_b[7:0], col_b[0], 7'(j)};
  end

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_output();
    checks++;
    if (image_a !== exp_flat_a) begin
      failures++;
      for (int i = 0; i < OH_A * OW_A; i++) begin
        if (image_a[i*DW +: DW] !== exp_flat_a[i*DW +: DW]) begin
          $display("[TB] FAIL image_a r=%0d c=%0d got=%h want=%h",
                   i / OW_A, i % OW_A, image_a[i*DW +: DW], exp_flat_a[i*DW +: DW]);
          break;
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy_a"}, 64'(busy_a), 0);
    check_val({tag, "_done_a"}, 64'(done_a), 0);
    check_val({tag, "_conv_start_a"}, 64'(conv_start_a), 0);
    check_val({tag, "_row_a"}, 64'(row_a), 0);
    check_val({tag, "_col_a"}, 64'(col_a), 0);
    check_val({tag, "_image_a_nonzero"}, 64'(|image_a), 0);
    check_val({tag, "_busy_b"}, 64'(busy_b), 0);
    check_val({tag, "_image_b_nonzero"}, 64'(|image_b), 0);
  endtask

  task automatic apply_stimulus(input bit lat_var, input bit spur, input logic [DW-1:0] xorv,
                                input int exp_cycles);
    done_exp_t de;
    m_lat_var = lat_var;
    m_spur    = spur;
    m_xor     = xorv;
    m_k       = 0;
    for (int r = 0; r < OH_A; r++)
      for (int c = 0; c < 2; c++)
        req_q.push_back('{row: 11'(r), col: 11'(c)});
    de.done_edge = edges + exp_cycles;
    de.pulses    = 2 * OH_A;
    done_q.push_back(de);
    start_a = 1'b1;
  endtask

  task automatic wait_row(input int r, input int c, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (conv_start_a && row_a == 11'(r) && col_a == 11'(c)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_row r=%0d c=%0d got=timeout want=issue", r, c);
    end
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_done got=timeout want=done");
    end
  endtask

  // Conv-unit model: answers each issue after a programmable WAIT latency,
  // optionally asserting conv_done with garbage in ISSUE and ADVANCE
  initial begin : conv_model
    logic [DW-1:0] word;
    forever begin
      @(negedge clk);
      conv_done_a   = 1'b0;
      conv_result_a = {HALF_A{16'hBAD5}};
      if (!busy_a) begin
        m_state = 0;
      end else if (m_state == 0) begin
        if (conv_start_a) begin
          m_lat = m_lat_var ? lat_tab[m_k % 4] : 1;
          m_row = m_k / 2;
          m_col = m_k % 2;
          m_k++;
          m_cnt   = 1;
          m_state = 1;
          if (m_spur) conv_done_a = 1'b1;
        end
      end else if (m_state == 1) begin
        if (m_cnt == m_lat) begin
          for (int j = 0; j < HALF_A; j++) begin
            word = {8'(m_row), 1'(m_col), 7'(j)} ^ m_xor;
            conv_result_a[j*DW +: DW] = word;
            exp_flat_a[((m_row * OW_A) + m_col * HALF_A + j) * DW +: DW] = word;
          end
          conv_done_a = 1'b1;
          m_state     = 2;
        end else begin
          m_cnt++;
        end
      end else begin
        if (m_spur) conv_done_a = 1'b1;
        m_state = 0;
      end
    end
  end

  // Monitor: compares each issue, held selector inputs and each done pulse
  initial begin : monitor_a
    int          pulses = 0;
    bit          have_last = 1'b0;
    logic [10:0] last_row = '0;
    logic [10:0] last_col = '0;
    req_t        rq;
    done_exp_t   de;
    forever begin
      @(negedge clk);
      if (!busy_a) begin
        have_last = 1'b0;
        pulses    = 0;
      end
      if (conv_start_a) begin
        pulses++;
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_issue got=row%0d/col%0d want=none", row_a, col_a);
        end else begin
          rq = req_q.pop_front();
          check_val("issue_row", 64'(row_a), 64'(rq.row));
          check_val("issue_col", 64'(col_a), 64'(rq.col));
        end
        last_row  = row_a;
        last_col  = col_a;
        have_last = 1'b1;
      end else if (busy_a && have_last) begin
        check_val("hold_row", 64'(row_a), 64'(last_row));
        check_val("hold_col", 64'(col_a), 64'(last_col));
      end
      if (done_a) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done got=done want=none");
        end else begin
          de = done_q.pop_front();
          check_val("done_edge", 64'(edges), 64'(de.done_edge));
          check_val("issue_pulses", 64'(pulses), 64'(de.pulses));
          check_output();
        end
      end
    end
  end

  // Directed sequence of passes
  initial begin : main
    int          sb;
    int          pulses_b;
    bit          found;
    logic [DW-1:0] want;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset");

    // Mid-pass reset once row 3 is issued
    apply_stimulus(1'b0, 1'b0, 16'h0000, 169);
    @(negedge clk);
    start_a = 1'b0;
    wait_row(3, 0, 200);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("mid_reset");
    req_q.delete();
    done_q.delete();
    exp_flat_a = '0;
    @(negedge clk);

    // Full pass, conv_done effectively high throughout: done at cycle 169
    apply_stimulus(1'b0, 1'b1, 16'h0000, 169);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(400);
    @(negedge clk);

    // Latencies 1,4,1,7 repeating: 56*2 + 14*13 + 1 = 295
    apply_stimulus(1'b1, 1'b1, 16'hFFFF, 295);
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_row(27, 1, 400);
    start_a = 1'b1;
    wait_done(100);
    @(negedge clk);
    // start still held in the IDLE cycle: a second pass begins at this edge
    apply_stimulus(1'b0, 1'b0, 16'h5A5A, 169);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(400);
    @(negedge clk);

    // Small geometry: 12 half-rows, done at cycle 37
    start_b  = 1'b1;
    sb       = edges + 1;
    pulses_b = 0;
    found    = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (conv_start_b) pulses_b++;
      if (done_b) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("b_done_seen", 64'(found), 1);
    check_val("b_done_cycle", 64'(edges - sb + 1), 37);
    check_val("b_issue_pulses", 64'(pulses_b), 12);
    for (int r = 0; r < OH_B; r++) begin
      for (int c = 0; c < OW_B; c++) begin
        want = {8'(r), 1'(c / HALF_B), 7'(c % HALF_B)};
        check_val($sformatf("b_image_r%0d_c%0d", r, c), 64'(image_b[(r*OW_B + c)*DW +: DW]), 64'(want));
      end
    end

    repeat (2) @(negedge clk);
    check_val("req_q_left", 64'(req_q.size()), 0);
    check_val("done_q_left", 64'(done_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
